// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared constants and types for the LEGv8 fetch sequencer:
//             NOP encoding, store/CBZ opcodes, XZR index, FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // ADD XZR, XZR, XZR -- architecturally harmless filler word
    localparam logic [31:0] C_NOP      = 32'h8B1F03FF;
    // Instruction [31:21] of STUR
    localparam logic [10:0] C_OPC_STUR = 11'h7C0;
    // Instruction [31:24] of CBZ
    localparam logic [7:0]  C_OPC_CBZ  = 8'hB4;
    // Register index of the zero register; never a real dependency
    localparam logic [4:0]  C_XZR      = 5'd31;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_sequencer_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Brief    : Combinational load-use hazard check between the load in ID/EX
//             and the source registers of the instruction held in IF/ID.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_detect
    import fetch_pkg::*;
(
    input  logic        ifid_valid_i,
    input  logic [10:0] ifid_opcode_i,   // instruction [31:21]
    input  logic [4:0]  ifid_rm_i,       // instruction [20:16]
    input  logic [4:0]  ifid_rn_i,       // instruction [9:5]
    input  logic [4:0]  ifid_rt_i,       // instruction [4:0]
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rd_i,
    output logic        hz_o
);

    logic w_rt_is_src;
    logic w_match;

    // STUR and CBZ read their Rt field, so it becomes a source operand too
    always_comb begin
        w_rt_is_src = (ifid_opcode_i == C_OPC_STUR) ||
                      (ifid_opcode_i[10:3] == C_OPC_CBZ);
        w_match     = (idex_rd_i == ifid_rn_i) ||
                      (idex_rd_i == ifid_rm_i) ||
                      (w_rt_is_src && (idex_rd_i == ifid_rt_i));
        hz_o        = ifid_valid_i && idex_memread_i &&
                      (idex_rd_i != C_XZR) && w_match;
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : PC owner and IF/ID register for the five-stage LEGv8 pipe.
//             Inserts one bubble on load-use hazards and redirects on taken
//             MEM-stage branches.
//             Option macro FETCH_BRANCH_SQUASH_EN: when defined, Flush follows
//             BranchTaken and each redirect counts 3 squash cycles; otherwise
//             Flush is 0 and only the IF/ID squash counts (1 cycle).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    output logic [63:0]      Address,
    input  logic [31:0]      Instruction,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rd,
    input  logic             BranchTaken,
    input  logic [63:0]      BranchTarget,
    output logic [31:0]      IFID_Instruction,
    output logic [63:0]      IFID_PC,
    output logic             IFID_Valid,
    output logic             Bubble,
    output logic             Flush,
    output logic [CNT_W-1:0] FetchCount,
    output logic [CNT_W-1:0] BubbleCount
);

    fetch_state_e     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic [63:0]      ifid_pc_q, ifid_pc_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic             w_hz;
    logic             w_advance;
    logic [1:0]       w_bub_inc;
    logic [CNT_W:0]   w_fetch_sum;
    logic [CNT_W+1:0] w_bub_sum;

    hazard_detect u_hazard_detect (
        .ifid_valid_i   (ifid_valid_q),
        .ifid_opcode_i  (ifid_instr_q[31:21]),
        .ifid_rm_i      (ifid_instr_q[20:16]),
        .ifid_rn_i      (ifid_instr_q[9:5]),
        .ifid_rt_i      (ifid_instr_q[4:0]),
        .idex_memread_i (IDEX_MemRead),
        .idex_rd_i      (IDEX_Rd),
        .hz_o           (w_hz)
    );

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect cancels any pending stall; STALL always lasts one cycle
    always_comb begin
        state_d = state_q;
        if (BranchTaken) begin
            state_d = RUN;
        end else if ((state_q == RUN) && w_hz) begin
            state_d = STALL;
        end else begin
            state_d = RUN;
        end
    end

    // Outputs: bubble only from RUN, and a redirect suppresses it
    always_comb begin
        Bubble    = (state_q == RUN) && w_hz && !BranchTaken;
        w_advance = !BranchTaken && !Bubble;
`ifdef FETCH_BRANCH_SQUASH_EN
        Flush     = BranchTaken;
        w_bub_inc = BranchTaken ? 2'd3 : {1'b0, Bubble};
`else
        Flush     = 1'b0;
        w_bub_inc = (BranchTaken || Bubble) ? 2'd1 : 2'd0;
`endif
    end

    // Datapath next values: redirect, hold on bubble, or sequential advance
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (BranchTaken) begin
            pc_d         = BranchTarget;
            ifid_instr_d = C_NOP;
            ifid_pc_d    = 64'h0;
            ifid_valid_d = 1'b0;
        end else if (w_advance) begin
            pc_d         = pc_q + 64'd4;
            ifid_instr_d = Instruction;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
        end

        // Saturating counters: a carry out of the counter width pins it at all-ones
        w_fetch_sum  = {1'b0, fetch_cnt_q} + {{CNT_W{1'b0}}, w_advance};
        fetch_cnt_d  = w_fetch_sum[CNT_W] ? {CNT_W{1'b1}} : w_fetch_sum[CNT_W-1:0];
        w_bub_sum    = {2'b00, bubble_cnt_q} + {{CNT_W{1'b0}}, w_bub_inc};
        bubble_cnt_d = (|w_bub_sum[CNT_W+1:CNT_W]) ? {CNT_W{1'b1}}
                                                    : w_bub_sum[CNT_W-1:0];
    end

    // PC, IF/ID and performance counter registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= C_NOP;
            ifid_pc_q    <= 64'h0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign Address          = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_Valid       = ifid_valid_q;
    assign FetchCount       = fetch_cnt_q;
    assign BubbleCount      = bubble_cnt_q;

endmodule : fetch_sequencer
`default_nettype wire
